// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
// Run controller for the cpu core. Sequences the core's active-high reset
// and drives its clock enable in one of three modes: free-run, run for a
// fixed number of enabled cycles, or single-step on rising edges of `step`.
// Counts enabled core cycles and records why the run ended.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset of this block
//   start        in   level; accepted only in IDLE or DONE
//   mode         in   00 free-run, 01 run-for-count, 10 single-step, 11 as 00
//   cycle_limit  in   enabled-cycle budget for run-for-count
//   step         in   single-step request (rising edge detected here)
//   stop         in   level; aborts RESET/RUN/STEP_WAIT/STEP
//   halt_in      in   halt indication from core; only seen while cpu_ce=1
//   cpu_rst      out  active-high reset to core
//   cpu_ce       out  clock enable to core
//   busy         out  high in RESET, RUN, STEP_WAIT, STEP
//   done         out  high in DONE
//   cycle_count  out  cpu_ce=1 cycles since last accepted start (saturating)
//   done_cause   out  00 none, 01 stop, 10 halt, 11 limit
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
   parameter int CNT_W        = 16,
   parameter int RESET_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] cycle_limit,
   input  logic             step,
   input  logic             stop,
   input  logic             halt_in,
   output logic             cpu_rst,
   output logic             cpu_ce,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] cycle_count,
   output logic [1:0]       done_cause
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_RUN,
      S_STEP_WAIT,
      S_STEP,
      S_DONE
   } state_t;

   localparam logic [1:0] MODE_FREE  = 2'b00;
   localparam logic [1:0] MODE_COUNT = 2'b01;
   localparam logic [1:0] MODE_STEP  = 2'b10;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_STOP  = 2'b01;
   localparam logic [1:0] CAUSE_HALT  = 2'b10;
   localparam logic [1:0] CAUSE_LIMIT = 2'b11;

   localparam int              RC_W    = $clog2(RESET_CYCLES + 1);
   localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RESET_CYCLES);
   localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);

   state_t             r_state;
   logic [1:0]         r_mode;
   logic [CNT_W-1:0]   r_limit;
   logic [CNT_W-1:0]   r_count;
   logic [1:0]         r_cause;
   logic [RC_W-1:0]    r_rst_cnt;
   logic               r_step_d;

   state_t             w_state_nxt;
   logic [1:0]         w_mode_nxt;
   logic [CNT_W-1:0]   w_limit_nxt;
   logic [CNT_W-1:0]   w_count_nxt;
   logic [1:0]         w_cause_nxt;
   logic [RC_W-1:0]    w_rst_cnt_nxt;

   logic               w_step_edge;
   logic [CNT_W-1:0]   w_count_inc;

   assign w_step_edge = step & ~r_step_d;

   // Saturating increment: once all-ones the count sticks.
   assign w_count_inc = (&r_count) ? r_count : r_count + CNT_W'(1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_mode    <= MODE_FREE;
         r_limit   <= '0;
         r_count   <= '0;
         r_cause   <= CAUSE_NONE;
         r_rst_cnt <= '0;
         r_step_d  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_mode    <= w_mode_nxt;
         r_limit   <= w_limit_nxt;
         r_count   <= w_count_nxt;
         r_cause   <= w_cause_nxt;
         r_rst_cnt <= w_rst_cnt_nxt;
         r_step_d  <= step;
      end
   end

   // NOTE: every signal written here gets a hold/default value first so no
   // path through the case leaves it unassigned (which would infer a latch).
   always_comb begin
      w_state_nxt   = r_state;
      w_mode_nxt    = r_mode;
      w_limit_nxt   = r_limit;
      w_count_nxt   = r_count;
      w_cause_nxt   = r_cause;
      w_rst_cnt_nxt = r_rst_cnt;

      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt   = S_RESET;
               // Mode 11 is folded into free-run at latch time.
               w_mode_nxt    = (mode == MODE_COUNT || mode == MODE_STEP) ? mode : MODE_FREE;
               w_limit_nxt   = cycle_limit;
               w_count_nxt   = '0;
               w_cause_nxt   = CAUSE_NONE;
               w_rst_cnt_nxt = RC_LOAD;
            end
         end

         S_RESET: begin
            if (stop) begin
               w_state_nxt = S_DONE;
               w_cause_nxt = CAUSE_STOP;
            end else if (r_rst_cnt == RC_ONE) begin
               if (r_mode == MODE_STEP) begin
                  w_state_nxt = S_STEP_WAIT;
               end else if (r_mode == MODE_COUNT && r_limit == '0) begin
                  // A zero budget ends the run without a single enabled cycle.
                  w_state_nxt = S_DONE;
                  w_cause_nxt = CAUSE_LIMIT;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end else begin
               w_rst_cnt_nxt = r_rst_cnt - RC_ONE;
            end
         end

         S_RUN: begin
            // The cycle in which stop/halt is seen is itself an enabled cycle.
            w_count_nxt = w_count_inc;
            if (stop) begin
               w_state_nxt = S_DONE;
               w_cause_nxt = CAUSE_STOP;
            end else if (halt_in) begin
               w_state_nxt = S_DONE;
               w_cause_nxt = CAUSE_HALT;
            end else if (r_mode == MODE_COUNT && w_count_inc == r_limit) begin
               w_state_nxt = S_DONE;
               w_cause_nxt = CAUSE_LIMIT;
            end
         end

         S_STEP_WAIT: begin
            if (stop) begin
               w_state_nxt = S_DONE;
               w_cause_nxt = CAUSE_STOP;
            end else if (w_step_edge) begin
               w_state_nxt = S_STEP;
            end
         end

         S_STEP: begin
            // Always returns to STEP_WAIT; an edge arriving now is already
            // absorbed into r_step_d and cannot trigger a second step.
            w_count_nxt = w_count_inc;
            if (stop) begin
               w_state_nxt = S_DONE;
               w_cause_nxt = CAUSE_STOP;
            end else if (halt_in) begin
               w_state_nxt = S_DONE;
               w_cause_nxt = CAUSE_HALT;
            end else begin
               w_state_nxt = S_STEP_WAIT;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs depend on registered state only.
   assign cpu_rst     = (r_state == S_IDLE) || (r_state == S_RESET);
   assign cpu_ce      = (r_state == S_RUN)  || (r_state == S_STEP);
   assign busy        = (r_state == S_RESET) || (r_state == S_RUN) ||
                        (r_state == S_STEP_WAIT) || (r_state == S_STEP);
   assign done        = (r_state == S_DONE);
   assign cycle_count = r_count;
   assign done_cause  = r_cause;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Self-checking bench for cpu_run_ctrl (CNT_W=4, RESET_CYCLES=2). A
// behavioural model tracks run phase with plain counters and flags; all DUT
// outputs are compared against it after every clock, plus directed checks
// on run lengths and end causes.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

   localparam int CNT_W = 4;
   localparam int RC    = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [1:0]       mode;
   logic [CNT_W-1:0] cycle_limit;
   logic             step;
   logic             stop;
   logic             halt_in;
   logic             cpu_rst;
   logic             cpu_ce;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] cycle_count;
   logic [1:0]       done_cause;

   cpu_run_ctrl #(
      .CNT_W        (CNT_W),
      .RESET_CYCLES (RC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .mode        (mode),
      .cycle_limit (cycle_limit),
      .step        (step),
      .stop        (stop),
      .halt_in     (halt_in),
      .cpu_rst     (cpu_rst),
      .cpu_ce      (cpu_ce),
      .busy        (busy),
      .done        (done),
      .cycle_count (cycle_count),
      .done_cause  (done_cause)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   // Reference model: a run is "busy" with some reset cycles left, then
   // either enabled every cycle (free/count) or enabled only while a step is
   // being taken; "done" holds count and cause until the next start.
   bit m_busy, m_done, m_stepping, m_prev_step;
   int m_rst_left, m_mode, m_limit, m_count, m_cause;

   int ce_seen;
   int rst_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      m_busy = 0; m_done = 0; m_stepping = 0; m_prev_step = 0;
      m_rst_left = 0; m_mode = 0; m_limit = 0; m_count = 0; m_cause = 0;
   endfunction

   function automatic bit m_idle();
      return !m_busy && !m_done;
   endfunction

   function automatic bit m_ce();
      return m_busy && (m_rst_left == 0) && (m_mode != 2 || m_stepping);
   endfunction

   function automatic bit m_cpu_rst();
      return m_idle() || (m_rst_left > 0);
   endfunction

   function automatic void m_end(input int cause);
      m_busy = 0; m_done = 1; m_cause = cause; m_stepping = 0; m_rst_left = 0;
   endfunction

   // Advance the model by one clock using the inputs currently driven.
   function automatic void m_step();
      bit edge_seen;
      edge_seen = step && !m_prev_step;
      if (!m_busy) begin
         if (start) begin
            m_busy = 1; m_done = 0; m_stepping = 0;
            m_mode = (mode == 2'b11) ? 0 : int'(mode);
            m_limit = int'(cycle_limit);
            m_count = 0; m_cause = 0; m_rst_left = RC;
         end
      end else if (m_rst_left > 0) begin
         if (stop) m_end(1);
         else begin
            m_rst_left--;
            if (m_rst_left == 0 && m_mode == 1 && m_limit == 0) m_end(3);
         end
      end else if (!m_ce()) begin
         if (stop) m_end(1);
         else if (edge_seen) m_stepping = 1;
      end else begin
         if (m_count < CMAX) m_count++;
         m_stepping = 0;
         if (stop) m_end(1);
         else if (halt_in) m_end(2);
         else if (m_mode == 1 && m_count == m_limit) m_end(3);
      end
      m_prev_step = step;
   endfunction

   task automatic compare_all();
      check("cpu_rst", cpu_rst, m_cpu_rst());
      check("cpu_ce", cpu_ce, m_ce());
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("cycle_count", cycle_count, m_count);
      check("done_cause", done_cause, m_cause);
   endtask

   task automatic tick();
      if (!rst) m_reset();
      else m_step();
      @(posedge clk);
      #1;
      ce_seen  += int'(cpu_ce);
      rst_seen += int'(cpu_rst);
      compare_all();
   endtask

   task automatic run_until_done(input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      check("run_terminates", done, 1'b1);
   endtask

   // Free-run; halt_in held high while cpu_ce=0 (must be ignored), then
   // pulsed on the 7th enabled cycle, optionally together with stop.
   task automatic run_free_halt(input bit with_stop);
      int e, n;
      mode = 2'b00; start = 1; tick(); start = 0;
      e = 0; n = 0;
      while (!done && n < 64) begin
         if (m_ce()) begin
            e++;
            halt_in = (e == 7);
            stop    = with_stop && (e == 7);
         end else begin
            halt_in = 1;
            stop    = 0;
         end
         tick();
         n++;
      end
      halt_in = 0; stop = 0;
      check("free_done", done, 1'b1);
      check("free_count", cycle_count, 7);
      check("free_cause", done_cause, with_stop ? 1 : 2);
   endtask

   initial begin
      rst = 0; start = 0; mode = 2'b00; cycle_limit = '0;
      step = 0; stop = 0; halt_in = 0;
      m_reset();

      // Reset / idle
      tick(); tick();
      rst = 1;
      tick();
      check("idle_cpu_rst", cpu_rst, 1'b1);
      check("idle_cpu_ce", cpu_ce, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
      check("idle_count", cycle_count, 0);

      // Run-for-count, limit 5
      mode = 2'b01; cycle_limit = 5; start = 1;
      rst_seen = 0; ce_seen = 0;
      tick(); start = 0;
      run_until_done(40);
      check("cnt5_rst_len", rst_seen, RC);
      check("cnt5_ce_len", ce_seen, 5);
      check("cnt5_count", cycle_count, 5);
      check("cnt5_cause", done_cause, 2'b11);
      check("cnt5_cpu_rst_low", cpu_rst, 1'b0);

      // Run-for-count, limit 0
      cycle_limit = 0; start = 1; ce_seen = 0;
      tick(); start = 0;
      run_until_done(20);
      check("cnt0_ce_len", ce_seen, 0);
      check("cnt0_count", cycle_count, 0);
      check("cnt0_cause", done_cause, 2'b11);

      // Free-run ended by halt, then by simultaneous stop+halt
      run_free_halt(1'b0);
      run_free_halt(1'b1);

      // Single-step
      mode = 2'b10; start = 1; tick(); start = 0;
      ce_seen = 0;
      repeat (RC) tick();
      step = 1; repeat (4) tick();
      step = 0; repeat (2) tick();
      step = 1; tick();
      step = 0; repeat (2) tick();
      // start while busy must not restart the run
      start = 1; mode = 2'b00; tick(); start = 0;
      check("step_busy_ignore", busy, 1'b1);
      check("step_pulses", ce_seen, 2);
      check("step_count", cycle_count, 2);
      // stop beats a simultaneous step edge
      stop = 1; step = 1; tick(); stop = 0; step = 0;
      check("step_stop_done", done, 1'b1);
      check("step_stop_cause", done_cause, 2'b01);
      check("step_stop_count", cycle_count, 2);
      check("step_stop_ce", ce_seen, 2);

      // Saturation
      mode = 2'b00; start = 1; tick(); start = 0;
      repeat (RC) tick();
      repeat (20) tick();
      stop = 1; tick(); stop = 0;
      check("sat_count", cycle_count, CMAX);
      check("sat_cause", done_cause, 2'b01);

      // Restart from DONE
      start = 1; rst_seen = 0; tick(); start = 0;
      check("restart_count", cycle_count, 0);
      check("restart_cause", done_cause, 2'b00);
      for (int i = 0; i < 10 && cpu_rst; i++) tick();
      check("restart_rst_len", rst_seen, RC);
      repeat (3) tick();
      check("abort_pre_ce", cpu_ce, 1'b1);

      // Asynchronous abort between clock edges
      #3;
      rst = 0;
      #1;
      check("abort_ce", cpu_ce, 1'b0);
      check("abort_cpu_rst", cpu_rst, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_count", cycle_count, 0);
      m_reset();
      tick();
      rst = 1;
      tick();

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         rst         = ($urandom_range(0, 199) != 0);
         start       = ($urandom_range(0, 7) == 0);
         mode        = 2'($urandom_range(0, 3));
         cycle_limit = ($urandom_range(0, 9) == 0) ? CNT_W'(CMAX) : CNT_W'($urandom_range(0, 8));
         step        = ($urandom_range(0, 1) == 1);
         stop        = ($urandom_range(0, 29) == 0);
         halt_in     = ($urandom_range(0, 14) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Parametrised run controller for the cpu core; replaces hand-toggled clk/reset sequencing with a synthesizable sequencer.
- Generates the core's active-high reset pulse and a clock-enable for the core.
- Supports three modes: free-run, run-for-N-cycles and single-step.
- Counts enabled core cycles and reports why the run ended: stop, halt or limit.

Parameters:
CNT_W, 16, width of cycle counter and cycle_limit
RESET_CYCLES, 2, cycles cpu_rst is held high after start (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset of this block
start  in  1  level; accepted only in IDLE or DONE
mode  in  2  00 free-run, 01 run-for-count, 10 single-step, 11 treated as 00; latched on accepted start
cycle_limit  in  CNT_W  enabled-cycle budget for mode 01; latched on accepted start
step  in  1  single-step request; rising edge detected internally
stop  in  1  level; aborts RESET/RUN/STEP_WAIT/STEP
halt_in  in  1  halt indication from core; sampled only when cpu_ce=1
cpu_rst  out  1  active-high reset to core
cpu_ce  out  1  clock enable to core
busy  out  1  high in RESET, RUN, STEP_WAIT, STEP
done  out  1  high in DONE
cycle_count  out  CNT_W  number of cpu_ce=1 cycles since last accepted start
done_cause  out  2  00 none, 01 stop, 10 halt, 11 limit

Behaviour:
- rst low (async): state=IDLE, cpu_rst=1, cpu_ce=0, busy=0, done=0, cycle_count=0, done_cause=00, step edge register=0, latched mode/limit=0. Deassertion is sampled on the next clk rising edge.
- Outputs are decoded from registered state/counters only; no combinational path from any input to any output.
- States: IDLE, RESET, RUN, STEP_WAIT, STEP, DONE.
- IDLE:
  - cpu_rst=1, cpu_ce=0.
  - start=1 -> RESET. Latch mode and limit, clear cycle_count, clear done_cause, load reset counter with RESET_CYCLES.
- RESET:
  - cpu_rst=1, cpu_ce=0. Exactly RESET_CYCLES cycles.
  - Then: mode 10 -> STEP_WAIT; mode 01 with limit=0 -> DONE (cause 11, count 0); otherwise -> RUN.
  - stop=1 -> DONE, cause 01, count 0.
- RUN:
  - cpu_rst=0, cpu_ce=1; cycle_count increments each cycle.
  - Counter saturates at all-ones; it never wraps.
  - Exit-test priority, evaluated on the same edge as the increment: stop (01) > halt_in (10) > limit reached (11).
  - Limit is reached when the post-increment count equals the latched limit. Mode 01 therefore yields exactly cycle_limit cycles with cpu_ce=1.
  - The cycle in which stop or halt is seen is counted.
  - Mode 00 runs until stop or halt.
- STEP_WAIT:
  - cpu_rst=0, cpu_ce=0.
  - Rising edge of step (step=1 and previous step=0) -> STEP.
  - Holding step high gives one step only.
  - stop=1 -> DONE, cause 01; stop has priority over a simultaneous step edge.
- STEP:
  - cpu_ce=1 for exactly one cycle; cycle_count increments.
  - Then: stop -> DONE (01); else halt_in -> DONE (10); else -> STEP_WAIT.
  - A step edge during STEP is ignored.
- DONE:
  - cpu_rst=0 so core state is preserved for inspection; cpu_ce=0.
  - done=1, busy=0; cycle_count and done_cause hold.
  - start=1 -> RESET, same actions as from IDLE. stop is ignored.
- start while busy is ignored.
- halt_in is ignored whenever cpu_ce=0.
- Async rst during any state aborts immediately to IDLE with the reset values above.

Test Plan:
- Reset/idle: rst=0 for 2 cycles, then 1 -> cpu_rst=1, cpu_ce=0, busy=0, done=0, count=0. start pulse with RESET_CYCLES=2 -> cpu_rst high exactly 2 more cycles, then falls.
- Run-for-count: mode=01, limit=5, start -> cpu_ce high exactly 5 consecutive cycles; then done=1, done_cause=11, cycle_count=5. limit=0 -> done after RESET, cpu_ce never high, count=0, cause=11.
- Free-run halt vs stop: mode=00, halt_in=1 on the 7th enabled cycle -> count=7, cause=10. Repeat with stop and halt_in both asserted on the same cycle -> cause=01.
- Single-step: mode=10; step held high 4 cycles, low, then one more pulse -> exactly 2 single-cycle cpu_ce pulses, count=2. stop -> done, cause=01, count=2.
- Saturation/restart: CNT_W=4, mode=00, run 20 cycles then stop -> count=15, cause=01. start from DONE -> count cleared to 0, cpu_rst reasserted for RESET_CYCLES.
- Async abort: assert rst low mid-RUN between clock edges -> cpu_ce drops and cpu_rst rises without waiting for a clk edge. start while busy produces no change.
